// File: rtl/time_ascii_fmt_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : time_ascii_fmt_if
// Description : Byte-stream valid/ready link from the time formatter to a
//               UART transmitter.
// Revision    : 1.0  initial release
// ============================================================================
interface time_ascii_fmt_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  // Byte producer: presents data/valid, observes ready.
  modport master (output tx_data, output tx_valid, input tx_ready);
  // Byte consumer: observes data/valid, drives ready.
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/time_ascii_fmt.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : time_ascii_fmt
// Description : Renders a packed-BCD time word as an ASCII text line and
//               streams it byte by byte over a valid/ready link. A line is
//               sent whenever the seconds byte changes or on a req pulse;
//               at most one further line is queued while a line is in flight.
//               Build option macro TIME_FMT_DATE_EN:
//                 defined   -> "CCYY-MM-DD hh:mm:ss" + EOL
//                 undefined -> "hh:mm:ss" + EOL
// Revision    : 1.0  initial release
// ============================================================================
module time_ascii_fmt #(
  parameter logic [7:0] CENTURY = 8'h20,
  parameter int         CR_EN   = 1
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic [47:0]  time_num,
  input  wire logic         req,
  output logic              busy,
  time_ascii_fmt_if.master  tx
);

  // Text characters before the end-of-line sequence.
`ifdef TIME_FMT_DATE_EN
  localparam int TEXT_LEN = 19;
`else
  localparam int TEXT_LEN = 8;
`endif
  localparam int         LINE_LEN = TEXT_LEN + ((CR_EN != 0) ? 2 : 1);
  localparam logic [4:0] LAST_IDX = 5'(LINE_LEN - 1);
  localparam logic [4:0] CR_IDX   = 5'(TEXT_LEN);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state;
  logic [47:0] snap;
  logic [4:0]  idx;
  logic        pending;
  logic [7:0]  prev_sec;
  logic        valid;
  logic [7:0]  ch;
  logic        trig;
  logic        xfer;
  logic        last_xfer;

  // One BCD nibble to its ASCII digit; non-decimal nibbles print as '?'.
  function automatic logic [7:0] digit(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3F;
  endfunction

  assign trig      = (time_num[7:0] != prev_sec) || req;
  assign xfer      = valid && tx.tx_ready;
  assign last_xfer = xfer && (idx == LAST_IDX);

  // Character selection from the frozen snapshot at the current line position.
  always_comb begin
    ch = 8'h0A;
    if ((CR_EN != 0) && (idx == CR_IDX)) begin
      ch = 8'h0D;
    end else begin
      case (idx)
`ifdef TIME_FMT_DATE_EN
        5'd0:    ch = digit(CENTURY[7:4]);
        5'd1:    ch = digit(CENTURY[3:0]);
        5'd2:    ch = digit(snap[47:44]);
        5'd3:    ch = digit(snap[43:40]);
        5'd4:    ch = 8'h2D;
        5'd5:    ch = digit(snap[39:36]);
        5'd6:    ch = digit(snap[35:32]);
        5'd7:    ch = 8'h2D;
        5'd8:    ch = digit(snap[31:28]);
        5'd9:    ch = digit(snap[27:24]);
        5'd10:   ch = 8'h20;
        5'd11:   ch = digit(snap[23:20]);
        5'd12:   ch = digit(snap[19:16]);
        5'd13:   ch = 8'h3A;
        5'd14:   ch = digit(snap[15:12]);
        5'd15:   ch = digit(snap[11:8]);
        5'd16:   ch = 8'h3A;
        5'd17:   ch = digit(snap[7:4]);
        5'd18:   ch = digit(snap[3:0]);
`else
        5'd0:    ch = digit(snap[23:20]);
        5'd1:    ch = digit(snap[19:16]);
        5'd2:    ch = 8'h3A;
        5'd3:    ch = digit(snap[15:12]);
        5'd4:    ch = digit(snap[11:8]);
        5'd5:    ch = 8'h3A;
        5'd6:    ch = digit(snap[7:4]);
        5'd7:    ch = digit(snap[3:0]);
`endif
        default: ch = 8'h0A;
      endcase
    end
  end

`ifndef TIME_FMT_DATE_EN
  // The date fields and century prefix have no place in the time-only line.
  logic unused_date;
  assign unused_date = ^{snap[47:24], CENTURY};
`endif

  // Line sequencer: trigger capture, snapshot, byte index and one-deep queue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      snap     <= 48'h0;
      idx      <= 5'd0;
      pending  <= 1'b0;
      valid    <= 1'b0;
      prev_sec <= time_num[7:0];
    end else begin
      prev_sec <= time_num[7:0];
      case (state)
        IDLE: begin
          if (trig) begin
            snap  <= time_num;
            idx   <= 5'd0;
            valid <= 1'b1;
            state <= SEND;
          end
        end
        SEND: begin
          if (last_xfer) begin
            idx <= 5'd0;
            if (pending || trig) begin
              // Queued line restarts immediately with a fresh snapshot.
              snap    <= time_num;
              pending <= 1'b0;
            end else begin
              valid <= 1'b0;
              state <= IDLE;
            end
          end else begin
            if (xfer) begin
              idx <= idx + 5'd1;
            end
            if (trig) begin
              pending <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign tx.tx_valid = valid;
  assign tx.tx_data  = (state == SEND) ? ch : 8'h00;
  assign busy        = (state == SEND);

endmodule
`default_nettype wire

// File: tb/tb_time_ascii_fmt.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_time_ascii_fmt
// Description : Directed self-checking bench for time_ascii_fmt (default
//               parameters; follows the TIME_FMT_DATE_EN build option).
// Revision    : 1.0  initial release
// ============================================================================
module tb_time_ascii_fmt;

  logic        clk;
  logic        rst_n;
  logic [47:0] time_num;
  logic        req;
  logic        busy;
  int          checks;
  int          failures;
  string       pre;
  string       s;

  time_ascii_fmt_if tx ();

  time_ascii_fmt dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .time_num (time_num),
    .req      (req),
    .busy     (busy),
    .tx       (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One byte transfer, optionally preceded by stall cycles with ready low.
  task automatic xfer(input logic [7:0] exp, input string tag, input int stall);
    logic [7:0] held;
    for (int k = 0; k < stall; k++) begin
      tx.tx_ready = 1'b0;
      held = tx.tx_data;
      @(negedge clk);
      check({24'h0, tx.tx_data}, {24'h0, held}, {tag, "_hold"});
      check({31'h0, tx.tx_valid}, 32'h1, {tag, "_vhold"});
    end
    tx.tx_ready = 1'b1;
    check({31'h0, tx.tx_valid}, 32'h1, {tag, "_valid"});
    check({24'h0, tx.tx_data}, {24'h0, exp}, tag);
    @(negedge clk);
  endtask

  task automatic run_line(input string exp, input string tag, input int stall);
    int guard;
    guard = 0;
    while ((tx.tx_valid !== 1'b1) && (guard < 8)) begin
      @(negedge clk);
      guard++;
    end
    check({31'h0, tx.tx_valid}, 32'h1, {tag, "_start"});
    for (int i = 0; i < exp.len(); i++) begin
      xfer(exp[i], $sformatf("%s_b%0d", tag, i), stall);
    end
  endtask

  task automatic check_idle(input string tag);
    check({31'h0, tx.tx_valid}, 32'h0, {tag, "_valid0"});
    check({31'h0, busy}, 32'h0, {tag, "_busy0"});
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    req         = 1'b0;
    time_num    = 48'h23_01_01_12_00_00;
    tx.tx_ready = 1'b1;
`ifdef TIME_FMT_DATE_EN
    pre = "2023-01-01 ";
`else
    pre = "";
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check_idle("rst");
    check({24'h0, tx.tx_data}, 32'h0, "rst_data");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_idle("release_quiet");

    // 1: seconds change -> one full line back-to-back
    time_num[7:0] = 8'h01;
    @(negedge clk);
    check({31'h0, tx.tx_valid}, 32'h1, "t1_latency");
    check({31'h0, busy}, 32'h1, "t1_busy");
    s = {pre, "12:00:01\015\012"};
    run_line(s, "t1", 0);
    check_idle("t1_end");

    // 2: ready high one cycle in three
    time_num[7:0] = 8'h02;
    @(negedge clk);
    s = {pre, "12:00:02\015\012"};
    run_line(s, "t2", 2);
    check_idle("t2_end");

    // 3: two changes during a line merge into one follow-on line
    time_num[7:0] = 8'h01;
    @(negedge clk);
    s = {pre, "12:00:01\015\012"};
    for (int i = 0; i < s.len(); i++) begin
      if (i == 5) time_num[7:0] = 8'h02;
      if (i == 9) time_num[7:0] = 8'h03;
      xfer(s[i], $sformatf("t3a_b%0d", i), 0);
    end
    check({31'h0, tx.tx_valid}, 32'h1, "t3_nobubble");
    s = {pre, "12:00:03\015\012"};
    run_line(s, "t3b", 0);
    check_idle("t3_end");
    repeat (5) @(negedge clk);
    check_idle("t3_no_third");

    // 4: non-decimal seconds nibble prints '?'
    time_num[7:0] = 8'h0A;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    s = {pre, "12:00:0?\015\012"};
    run_line(s, "t4", 0);
    check_idle("t4_end");
    repeat (4) @(negedge clk);
    check_idle("t4_single");

    // 5: reset mid-line aborts and stays quiet
    time_num[7:0] = 8'h04;
    @(negedge clk);
    s = {pre, "12:00:04\015\012"};
    for (int i = 0; i < 7; i++) begin
      xfer(s[i], $sformatf("t5_b%0d", i), 0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("t5_rst");
    check({24'h0, tx.tx_data}, 32'h0, "t5_data");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_idle("t5_quiet");

    // 6: req with static time, second req queues exactly one more line
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check({31'h0, tx.tx_valid}, 32'h1, "t6_latency");
    for (int i = 0; i < s.len(); i++) begin
      if (i == 3) req = 1'b1;
      xfer(s[i], $sformatf("t6a_b%0d", i), 0);
      req = 1'b0;
    end
    check({31'h0, tx.tx_valid}, 32'h1, "t6_nobubble");
    run_line(s, "t6b", 0);
    check_idle("t6_end");
    repeat (5) @(negedge clk);
    check_idle("t6_no_third");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
